// File: rtl/led_pkg.sv
// led_pkg: shared FSM state type and default parameter values for the LED status controller
package led_pkg;
  typedef enum logic {LAMP, RUN} state_t;
  localparam int NUM_LEDS_D    = 16;
  localparam int NUM_PAGES_D   = 8;
  localparam int NUM_STICKY_D  = 8;
  localparam int PWM_W_D       = 8;
  localparam int BLINK_W_D     = 24;
  localparam int LAMP_CYCLES_D = 1024;
endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running PWM counter with duty compare and period-end strobe
// Ports: sysclk/reset_n clock and async low reset; brightness duty value;
//        pwm_on duty-active flag; period_end high on the last count of a period.
module led_pwm import led_pkg::*; #(
  parameter int PWM_W = PWM_W_D
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic [PWM_W-1:0] brightness,
  output logic             pwm_on,
  output logic             period_end
);
  logic [PWM_W-1:0] pwm_cnt;
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 1'b1;
  // full-scale brightness holds the LEDs solidly on instead of losing one count per period
  assign pwm_on = &brightness || pwm_cnt < brightness;
  assign period_end = &pwm_cnt;
endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: paged LED display with PWM dimming, blink gating, sticky flags and lamp test
// Ports: sysclk/reset_n clock and async low reset; page_data flattened pages;
//        page_sel requested page (NUM_PAGES = sticky page); brightness PWM duty;
//        blink_mask blink-gated LEDs; sticky_set/sticky_clr flag control;
//        lamp_test_req lamp test pulse; led registered drive; sticky_q flags;
//        active_page displayed page; lamp_active high during lamp test.
module led_status_ctrl import led_pkg::*; #(
  parameter  int NUM_LEDS    = NUM_LEDS_D,
  parameter  int NUM_PAGES   = NUM_PAGES_D,
  parameter  int NUM_STICKY  = NUM_STICKY_D,
  parameter  int PWM_W       = PWM_W_D,
  parameter  int BLINK_W     = BLINK_W_D,
  parameter  int LAMP_CYCLES = LAMP_CYCLES_D,
  localparam int SEL_W       = $clog2(NUM_PAGES + 1)
) (
  input  logic                          sysclk,
  input  logic                          reset_n,
  input  logic [NUM_PAGES*NUM_LEDS-1:0] page_data,
  input  logic [SEL_W-1:0]              page_sel,
  input  logic [PWM_W-1:0]              brightness,
  input  logic [NUM_LEDS-1:0]           blink_mask,
  input  logic [NUM_STICKY-1:0]         sticky_set,
  input  logic [NUM_STICKY-1:0]         sticky_clr,
  input  logic                          lamp_test_req,
  output logic [NUM_LEDS-1:0]           led,
  output logic [NUM_STICKY-1:0]         sticky_q,
  output logic [SEL_W-1:0]              active_page,
  output logic                          lamp_active
);
  localparam int LAMP_W = $clog2(LAMP_CYCLES + 1);
  state_t              state;
  logic [LAMP_W-1:0]   lamp_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [NUM_LEDS-1:0] sel_q;
  logic [NUM_LEDS-1:0] sel_d;
  logic                pwm_on;
  logic                period_end;
  logic                blink_phase;
  int                  pidx;
  led_pwm #(.PWM_W(PWM_W)) u_pwm (
    .sysclk(sysclk),
    .reset_n(reset_n),
    .brightness(brightness),
    .pwm_on(pwm_on),
    .period_end(period_end)
  );
  assign blink_phase = blink_cnt[BLINK_W-1];
  assign lamp_active = state == LAMP;
  // index is clamped so the part-select never reaches past page_data
  assign pidx = int'(active_page) < NUM_PAGES ? int'(active_page) : 0;
  always_comb
    sel_d = int'(active_page) < NUM_PAGES  ? page_data[pidx*NUM_LEDS +: NUM_LEDS] :
            int'(active_page) == NUM_PAGES ? NUM_LEDS'(sticky_q) : '0;
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      blink_cnt   <= '0;
      active_page <= '0;
      sel_q       <= '0;
      sticky_q    <= '0;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
      // pages switch only at PWM period boundaries so a period never mixes two pages
      active_page <= period_end ? page_sel : active_page;
      sel_q       <= sel_d;
      sticky_q    <= sticky_set | (sticky_q & ~sticky_clr);
    end
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      state    <= LAMP;
      lamp_cnt <= '0;
      led      <= '0;
    end else if (state == LAMP) begin
      led      <= '1;
      lamp_cnt <= lamp_cnt + 1'b1;
      if (lamp_cnt == LAMP_W'(LAMP_CYCLES - 1)) state <= RUN;
    end else begin
      led <= sel_q & {NUM_LEDS{pwm_on}} & ~(blink_mask & {NUM_LEDS{~blink_phase}});
      if (lamp_test_req) begin
        state    <= LAMP;
        lamp_cnt <= '0;
      end
    end
endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: self-checking bench for led_status_ctrl against a cycle-count reference model
module tb_led_status_ctrl;
  localparam int NL = 16, NP = 8, NS = 8, PW = 8, BW = 5, LC = 16, SW = 4;
  logic             sysclk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NP*NL-1:0] page_data = '0;
  logic [SW-1:0]    page_sel = '0;
  logic [PW-1:0]    brightness = '0;
  logic [NL-1:0]    blink_mask = '0;
  logic [NS-1:0]    sticky_set = '0;
  logic [NS-1:0]    sticky_clr = '0;
  logic             lamp_test_req = 1'b0;
  logic [NL-1:0]    led;
  logic [NS-1:0]    sticky_q;
  logic [SW-1:0]    active_page;
  logic             lamp_active;
  int checks = 0;
  int failures = 0;
  led_status_ctrl #(.NUM_LEDS(NL), .NUM_PAGES(NP), .NUM_STICKY(NS), .PWM_W(PW),
                    .BLINK_W(BW), .LAMP_CYCLES(LC)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .page_data(page_data), .page_sel(page_sel),
    .brightness(brightness), .blink_mask(blink_mask), .sticky_set(sticky_set),
    .sticky_clr(sticky_clr), .lamp_test_req(lamp_test_req), .led(led),
    .sticky_q(sticky_q), .active_page(active_page), .lamp_active(lamp_active)
  );
  always #5 sysclk = ~sysclk;
  // reference model: k counts clock edges since reset release, so the PWM position
  // is k mod 256 and the blink phase is the upper half of each 32-cycle blink period
  int            k;
  int            e_left;
  logic [NL-1:0] e_led, e_sel;
  logic [NS-1:0] e_sticky;
  logic [SW-1:0] e_page;
  logic          e_lamp;
  assign e_lamp = e_left > 0;
  function automatic logic [NL-1:0] page_view(input int p, input logic [NS-1:0] st,
                                              input logic [NP*NL-1:0] pd);
    if (p < NP) return pd[p*NL +: NL];
    if (p == NP) return {8'h00, st};
    return '0;
  endfunction
  always @(posedge sysclk or negedge reset_n) begin
    int   pc;
    logic bp, on;
    if (!reset_n) begin
      k <= 0; e_left <= LC; e_led <= '0; e_sel <= '0; e_sticky <= '0; e_page <= '0;
    end else begin
      pc = k % 256;
      bp = (k % 32) >= 16;
      on = brightness == 8'hFF || pc < int'(brightness);
      e_led    <= e_left > 0 ? '1 : e_sel & {NL{on}} & ~(blink_mask & {NL{~bp}});
      e_sel    <= page_view(int'(e_page), e_sticky, page_data);
      e_page   <= pc == 255 ? page_sel : e_page;
      e_sticky <= sticky_set | (e_sticky & ~sticky_clr);
      e_left   <= e_left > 0 ? e_left - 1 : (lamp_test_req ? LC : 0);
      k        <= k + 1;
    end
  end
  task automatic tick();
    @(negedge sysclk);
  endtask
  task automatic load_pages();
    for (int p = 0; p < NP; p++) page_data[p*NL +: NL] = NL'($urandom);
    page_data[NL +: NL] = 16'hA5A5;
  endtask
  task automatic wait_page(input logic [SW-1:0] p, input string nm);
    int n = 0;
    while (active_page !== p && n < 300) begin tick(); n++; end
    checks++;
    if (active_page !== p) begin failures++; $display("FAIL %s_timeout active_page=%0d want=%0d", nm, active_page, p); end
    checks++;
    if (active_page !== e_page) begin failures++; $display("FAIL %s_switch_time active_page=%0d want=%0d", nm, active_page, e_page); end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    load_pages();
    repeat (3) tick();
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h want=0000", led); end
    checks++; if (sticky_q !== 8'h0) begin failures++; $display("FAIL reset_sticky got=%h want=00", sticky_q); end
    checks++; if (active_page !== 4'd0) begin failures++; $display("FAIL reset_page got=%0d want=0", active_page); end
    checks++; if (lamp_active !== 1'b1) begin failures++; $display("FAIL reset_lamp got=%b want=1", lamp_active); end
  endtask
  task automatic test_lamp_startup();
    reset_n = 1'b1;
    brightness = 8'hFF;
    for (int i = 1; i <= LC; i++) begin
      tick();
      checks++; if (led !== 16'hFFFF) begin failures++; $display("FAIL startup_led cyc=%0d got=%h want=ffff", i, led); end
      checks++; if (lamp_active !== (i < LC)) begin failures++; $display("FAIL startup_lamp cyc=%0d got=%b want=%b", i, lamp_active, i < LC); end
    end
    tick();
    checks++; if (led !== e_led) begin failures++; $display("FAIL startup_run_led got=%h want=%h", led, e_led); end
  endtask
  task automatic test_page();
    page_sel = 4'd1; brightness = 8'hFF; blink_mask = '0;
    wait_page(4'd1, "page");
    repeat (2) tick();
    checks++; if (led !== 16'hA5A5) begin failures++; $display("FAIL page_led got=%h want=a5a5", led); end
  endtask
  task automatic test_pwm_duty();
    int cnt = 0;
    brightness = 8'h40;
    repeat (4) tick();
    repeat (256) begin tick(); if (led !== 16'h0) cnt++; end
    checks++; if (cnt != 64) begin failures++; $display("FAIL pwm_duty on_cycles=%0d want=64", cnt); end
    brightness = 8'h00;
    cnt = 0;
    repeat (4) tick();
    repeat (256) begin tick(); if (led !== 16'h0) cnt++; end
    checks++; if (cnt != 0) begin failures++; $display("FAIL pwm_zero on_cycles=%0d want=0", cnt); end
    brightness = 8'hFF;
  endtask
  task automatic test_sticky();
    page_sel = 4'd8;
    wait_page(4'd8, "sticky");
    sticky_set = 8'h08; sticky_clr = 8'h08;
    tick();
    sticky_set = '0; sticky_clr = '0;
    checks++; if (sticky_q !== 8'h08) begin failures++; $display("FAIL sticky_setwins got=%h want=08", sticky_q); end
    repeat (2) tick();
    checks++; if (led !== 16'h0008) begin failures++; $display("FAIL sticky_led got=%h want=0008", led); end
    sticky_clr = 8'h08;
    tick();
    sticky_clr = '0;
    checks++; if (sticky_q !== 8'h00) begin failures++; $display("FAIL sticky_clr got=%h want=00", sticky_q); end
    repeat (2) tick();
    checks++; if (led !== 16'h0000) begin failures++; $display("FAIL sticky_led_clr got=%h want=0000", led); end
  endtask
  task automatic test_lamp_req();
    page_sel = 4'd1;
    wait_page(4'd1, "lamp");
    repeat (3) tick();
    checks++; if (led !== 16'hA5A5) begin failures++; $display("FAIL lamp_pre_led got=%h want=a5a5", led); end
    lamp_test_req = 1'b1;
    tick();
    checks++; if (lamp_active !== 1'b1) begin failures++; $display("FAIL lamp_enter got=%b want=1", lamp_active); end
    for (int i = 1; i <= LC; i++) begin
      lamp_test_req = i == 5;
      tick();
      checks++; if (led !== 16'hFFFF) begin failures++; $display("FAIL lamp_led cyc=%0d got=%h want=ffff", i, led); end
    end
    lamp_test_req = 1'b0;
    checks++; if (lamp_active !== 1'b0) begin failures++; $display("FAIL lamp_exit got=%b want=0", lamp_active); end
    tick();
    checks++; if (led !== 16'hA5A5) begin failures++; $display("FAIL lamp_post_led got=%h want=a5a5", led); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      if (i % 64 == 0) load_pages();
      page_sel      = SW'($urandom_range(0, 15));
      brightness    = i % 3 == 0 ? 8'hFF : (i % 7 == 0 ? 8'h00 : PW'($urandom));
      blink_mask    = NL'($urandom);
      sticky_set    = NS'($urandom & $urandom & $urandom);
      sticky_clr    = NS'($urandom & $urandom);
      lamp_test_req = $urandom_range(0, 149) == 0;
      tick();
      checks++; if (led !== e_led) begin failures++; $display("FAIL rand_led cyc=%0d got=%h want=%h", i, led, e_led); end
      checks++; if (sticky_q !== e_sticky) begin failures++; $display("FAIL rand_sticky cyc=%0d got=%h want=%h", i, sticky_q, e_sticky); end
      checks++; if (active_page !== e_page) begin failures++; $display("FAIL rand_page cyc=%0d got=%0d want=%0d", i, active_page, e_page); end
      checks++; if (lamp_active !== e_lamp) begin failures++; $display("FAIL rand_lamp cyc=%0d got=%b want=%b", i, lamp_active, e_lamp); end
    end
    sticky_set = '0; sticky_clr = '0; lamp_test_req = 1'b0; blink_mask = '0; brightness = 8'hFF;
    load_pages();
    repeat (20) tick();
  endtask
  task automatic test_reset_mid();
    page_sel = 4'd1;
    wait_page(4'd1, "rstmid");
    repeat (3) tick();
    checks++; if (led !== 16'hA5A5) begin failures++; $display("FAIL rstmid_pre_led got=%h want=a5a5", led); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL rstmid_led got=%h want=0000", led); end
    checks++; if (lamp_active !== 1'b1) begin failures++; $display("FAIL rstmid_lamp got=%b want=1", lamp_active); end
    checks++; if (active_page !== 4'd0) begin failures++; $display("FAIL rstmid_page got=%0d want=0", active_page); end
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= LC; i++) begin
      tick();
      checks++; if (led !== 16'hFFFF) begin failures++; $display("FAIL rstmid_lamp_led cyc=%0d got=%h want=ffff", i, led); end
    end
    checks++; if (lamp_active !== 1'b0) begin failures++; $display("FAIL rstmid_lamp_end got=%b want=0", lamp_active); end
    repeat (4) tick();
    checks++; if (led !== e_led) begin failures++; $display("FAIL rstmid_run_led got=%h want=%h", led, e_led); end
  endtask
  initial begin
    test_reset();
    test_lamp_startup();
    test_page();
    test_pwm_duty();
    test_sticky();
    test_lamp_req();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 Param NUM_LEDS, default 16: LED output width.
REQ-002 Param NUM_PAGES, default 8: selectable display pages, at least 2.
REQ-003 Param NUM_STICKY, default 8: sticky event flags, at most NUM_LEDS.
REQ-004 Param PWM_W, default 8: PWM counter and brightness width.
REQ-005 Param BLINK_W, default 24: blink counter width.
REQ-006 Param LAMP_CYCLES, default 1024: lamp-test duration in cycles, at least 1.
REQ-007 Localparam SEL_W = $clog2(NUM_PAGES+1).
REQ-008 sysclk  in  1  sole clock; all logic is clocked on the rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 page_data  in  NUM_PAGES*NUM_LEDS  flattened pages; page p occupies bits [p*NUM_LEDS +: NUM_LEDS].
REQ-011 page_sel  in  SEL_W  requested page; the value NUM_PAGES selects the sticky page.
REQ-012 brightness  in  PWM_W  duty value.
REQ-013 blink_mask  in  NUM_LEDS  LEDs gated by the blink phase.
REQ-014 sticky_set  in  NUM_STICKY  per-flag set pulses.
REQ-015 sticky_clr  in  NUM_STICKY  per-flag synchronous clears.
REQ-016 lamp_test_req  in  1  pulse that requests a lamp test.
REQ-017 led  out  NUM_LEDS  registered LED drive.
REQ-018 sticky_q  out  NUM_STICKY  current sticky flags.
REQ-019 active_page  out  SEL_W  page currently displayed.
REQ-020 lamp_active  out  1  high while in the LAMP state.

Function
REQ-021 pwm_cnt (PWM_W bits) shall free-run and wrap from all-ones to 0.
REQ-022 pwm_on shall be 1 when brightness is all-ones or pwm_cnt < brightness.
  - brightness = 0: LEDs are always off.
REQ-023 blink_cnt (BLINK_W bits) shall free-run; blink_phase = blink_cnt[BLINK_W-1].
REQ-024 active_page shall load page_sel only on the cycle where pwm_cnt is all-ones.
  - Page switching therefore happens only at PWM period boundaries, which keeps it glitch-free.
REQ-025 Stage 1: sel_q shall register one of the following:
  - page active_page, when active_page < NUM_PAGES;
  - sticky_q zero-extended, when active_page = NUM_PAGES;
  - all zeros for any out-of-range active_page.
REQ-026 Stage 2 in RUN: led shall be registered as sel_q & {NUM_LEDS{pwm_on}} & ~(blink_mask & {NUM_LEDS{~blink_phase}}).
REQ-027 Latency from page_data to led shall be exactly 2 cycles when the page and the gating are unchanged.
REQ-028 Each sticky_q[i] shall update every cycle:
  - set when sticky_set[i];
  - else cleared when sticky_clr[i];
  - else held.
  - Simultaneous set and clear: set wins.
REQ-029 State LAMP: led shall be all-ones, ignoring PWM, blink and page.
  - lamp_cnt counts LAMP_CYCLES cycles, then the FSM moves to RUN.
REQ-030 State RUN: lamp_test_req=1 shall enter LAMP and restart lamp_cnt at 0.
  - lamp_test_req while already in LAMP is ignored; the count is not extended.
REQ-031 Sticky capture, the counters and active_page updates shall continue during LAMP.

Reset
REQ-032 Asserting reset_n low shall immediately clear the following, even mid-operation:
  - led, sel_q, sticky_q, pwm_cnt, blink_cnt, lamp_cnt: 0;
  - active_page: 0.
  - state: LAMP, with lamp_active = 1.
REQ-033 After reset_n is released, the first lamp test shall run for LAMP_CYCLES cycles before RUN.

Structure
REQ-034 Package led_pkg shall hold:
  - the state enum {LAMP, RUN};
  - the default parameter constants.
REQ-035 Sub-module led_pwm shall contain pwm_cnt, the compare logic and the period-end strobe; everything else stays in led_status_ctrl.

Verification
REQ-036 Setup NUM_LEDS=16, NUM_PAGES=8, PWM_W=8, LAMP_CYCLES=16; release reset_n -> led=16'hFFFF and lamp_active=1 for 16 cycles, then RUN.
REQ-037 brightness=8'hFF, page_sel=1, page 1=16'hA5A5 -> active_page=1 after the next pwm wrap, and led=16'hA5A5 two cycles later.
REQ-038 brightness=8'h40 -> led is nonzero for exactly 64 of every 256 cycles.
REQ-039 sticky_set[3] and sticky_clr[3] in the same cycle -> sticky_q[3]=1; a later clr-only pulse -> 0; page_sel=8 shows 16'h0008 while the flag is set.
REQ-040 Assert reset_n low mid-RUN with a page showing -> led=0 immediately, and the lamp test restarts on release.
REQ-041 lamp_test_req pulse in RUN -> led all-ones for 16 cycles, then returns to the page display.
